// File: rtl/pwr_rail_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwr_rail_seq : N-rail master power sequencer with settle delays, PG      |
// |                timeouts, runtime-fault latching and sticky leak shutdown |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module pwr_rail_seq #(
  parameter int NUM_RAILS = 4,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 4
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iTick_1ms,
  input  logic                       iAux_Good,
  input  logic                       iPwr_Req,
  input  logic                       iLeak_N,
  input  logic                       iFault_Clr,
  input  logic [NUM_RAILS-1:0]       iRail_PG,
  input  logic [NUM_RAILS*CNT_W-1:0] iRail_Dly,
  input  logic [CNT_W-1:0]           iPG_Timeout,
  output logic [NUM_RAILS-1:0]       oRail_EN,
  output logic [3:0]                 oState,
  output logic [IDX_W-1:0]           oRail_Idx,
  output logic [NUM_RAILS-1:0]       oSeq_Flt,
  output logic [NUM_RAILS-1:0]       oRun_Flt,
  output logic                       oLeak,
  output logic                       oAll_Good
);

  localparam logic [3:0] S_IDLE    = 4'h9;
  localparam logic [3:0] S_STANDBY = 4'h7;
  localparam logic [3:0] S_UP      = 4'h3;
  localparam logic [3:0] S_ON      = 4'h0;
  localparam logic [3:0] S_DOWN    = 4'h2;
  localparam logic [3:0] S_LEAK    = 4'hE;
  localparam logic [3:0] S_FAULT   = 4'hF;

  localparam int SW = NUM_RAILS + 3;
  // Leak detect is active low, so its synchroniser idles high out of reset.
  localparam logic [SW-1:0] SYNC_RST = {2'b00, 1'b1, {NUM_RAILS{1'b0}}};

  logic [SW-1:0]        meta_d, meta_q, sync_d, sync_q;
  logic                 aux_s, req_s, leakn_s;
  logic [NUM_RAILS-1:0] pg_s;

  logic [3:0]           state_d, state_q;
  logic [NUM_RAILS-1:0] en_d, en_q, seq_d, seq_q, run_d, run_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 seen_d, seen_q, pend_d, pend_q, leak_d, leak_q;
  logic                 all_good_d, all_good_q;

  logic [NUM_RAILS-1:0] sel, below, sel_up, sel_dn, lost;
  logic [CNT_W-1:0]     dly_cur, cnt_inc, dly_base, dly_nx;
  logic                 pg_cur, seq_to;

  always_comb begin
    meta_d = {iAux_Good, iPwr_Req, iLeak_N, iRail_PG};
    sync_d = meta_q;
  end

  assign aux_s   = sync_q[SW-1];
  assign req_s   = sync_q[SW-2];
  assign leakn_s = sync_q[SW-3];
  assign pg_s    = sync_q[NUM_RAILS-1:0];

  // One-hot decode of the active rail keeps all indexing within the rail vector.
  always_comb begin
    sel     = '0;
    below   = '0;
    dly_cur = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        sel[i]  = 1'b1;
        dly_cur = iRail_Dly[i*CNT_W +: CNT_W];
      end
      if (IDX_W'(i) < idx_q) below[i] = 1'b1;
    end
  end

  assign sel_up   = {sel[NUM_RAILS-2:0], 1'b0};
  assign sel_dn   = {1'b0, sel[NUM_RAILS-1:1]};
  assign pg_cur   = |(pg_s & sel);
  assign lost     = below & ~pg_s;
  assign cnt_inc  = (iTick_1ms && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign dly_base = seen_q ? cnt_q : '0;
  assign dly_nx   = (iTick_1ms && (dly_base != '1)) ? dly_base + CNT_W'(1) : dly_base;
  assign seq_to   = !pg_cur && !seen_q && (cnt_q >= iPG_Timeout);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    seq_d   = seq_q;
    run_d   = run_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    pend_d  = pend_q;
    leak_d  = leak_q;

    if (state_q == S_LEAK) begin
      en_d = '0;
    end else if (!aux_s) begin
      state_d = S_IDLE;
      en_d    = '0;
      idx_d   = '0;
      cnt_d   = '0;
      seen_d  = 1'b0;
    end else if ((state_q != S_IDLE) && !leakn_s) begin
      state_d = S_LEAK;
      en_d    = '0;
      leak_d  = 1'b1;
      cnt_d   = '0;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          en_d    = '0;
          idx_d   = '0;
          state_d = S_STANDBY;
        end
        S_STANDBY: begin
          en_d   = '0;
          idx_d  = '0;
          cnt_d  = '0;
          seen_d = 1'b0;
          if (req_s) begin
            state_d = S_UP;
            en_d    = NUM_RAILS'(1);
          end
        end
        S_UP: begin
          if ((|lost) || seq_to || !req_s) begin
            if (|lost) begin
              run_d  = run_q | lost;
              pend_d = 1'b1;
            end else if (seq_to) begin
              seq_d  = seq_q | sel;
              pend_d = 1'b1;
            end
            state_d = S_DOWN;
            en_d    = en_q & ~sel;
            cnt_d   = '0;
            seen_d  = 1'b0;
          end else if (!pg_cur) begin
            // PG dropping during settle restarts the wait for this rail.
            if (seen_q) begin
              seen_d = 1'b0;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (dly_nx >= dly_cur) begin
            cnt_d  = '0;
            seen_d = 1'b0;
            if (sel[NUM_RAILS-1]) begin
              state_d = S_ON;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              en_d  = en_q | sel_up;
            end
          end else begin
            seen_d = 1'b1;
            cnt_d  = dly_nx;
          end
        end
        S_ON: begin
          if ((|(~pg_s)) || !req_s) begin
            if (|(~pg_s)) begin
              run_d  = run_q | ~pg_s;
              pend_d = 1'b1;
            end
            state_d = S_DOWN;
            en_d    = en_q & ~sel;
            cnt_d   = '0;
          end
        end
        S_DOWN: begin
          if (!pg_cur || (cnt_q >= iPG_Timeout)) begin
            cnt_d = '0;
            if (sel[0]) begin
              state_d = pend_q ? S_FAULT : S_STANDBY;
            end else begin
              idx_d = idx_q - IDX_W'(1);
              en_d  = en_q & ~sel_dn;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FAULT: begin
          en_d = '0;
          if (iFault_Clr) begin
            seq_d   = '0;
            run_d   = '0;
            pend_d  = 1'b0;
            state_d = S_STANDBY;
          end
        end
        default: begin
          state_d = S_IDLE;
          en_d    = '0;
          idx_d   = '0;
        end
      endcase
    end

    all_good_d = (state_d == S_ON);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      meta_q     <= SYNC_RST;
      sync_q     <= SYNC_RST;
      state_q    <= S_IDLE;
      en_q       <= '0;
      seq_q      <= '0;
      run_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      pend_q     <= 1'b0;
      leak_q     <= 1'b0;
      all_good_q <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      state_q    <= state_d;
      en_q       <= en_d;
      seq_q      <= seq_d;
      run_q      <= run_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      pend_q     <= pend_d;
      leak_q     <= leak_d;
      all_good_q <= all_good_d;
    end
  end

  assign oRail_EN  = en_q;
  assign oState    = state_q;
  assign oRail_Idx = idx_q;
  assign oSeq_Flt  = seq_q;
  assign oRun_Flt  = run_q;
  assign oLeak     = leak_q;
  assign oAll_Good = all_good_q;

endmodule
`default_nettype wire

// File: tb/tb_pwr_rail_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwr_rail_seq : scoreboard bench for pwr_rail_seq (4 rails)            |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_pwr_rail_seq;

  typedef logic [21:0] snap_t;

  logic        iClk, iRst_n, iTick_1ms, iAux_Good, iPwr_Req, iLeak_N, iFault_Clr;
  logic [3:0]  iRail_PG;
  logic [63:0] iRail_Dly;
  logic [15:0] iPG_Timeout;
  logic [3:0]  oRail_EN, oState, oRail_Idx, oSeq_Flt, oRun_Flt;
  logic        oLeak, oAll_Good;

  logic [3:0]  stuck, drop;
  int          lat [4];
  int          tick_cnt;
  int          n_tests, n_fail;
  snap_t       exp_q [$];
  snap_t       last;

  pwr_rail_seq #(.NUM_RAILS(4), .CNT_W(16), .IDX_W(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iTick_1ms(iTick_1ms), .iAux_Good(iAux_Good),
    .iPwr_Req(iPwr_Req), .iLeak_N(iLeak_N), .iFault_Clr(iFault_Clr),
    .iRail_PG(iRail_PG), .iRail_Dly(iRail_Dly), .iPG_Timeout(iPG_Timeout),
    .oRail_EN(oRail_EN), .oState(oState), .oRail_Idx(oRail_Idx),
    .oSeq_Flt(oSeq_Flt), .oRun_Flt(oRun_Flt), .oLeak(oLeak), .oAll_Good(oAll_Good)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Tick every 10 clocks; each PG follows its enable after 5 cycles unless held low.
  initial begin
    iTick_1ms = 1'b0;
    iRail_PG  = '0;
    tick_cnt  = 0;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    forever begin
      @(negedge iClk);
      tick_cnt  = (tick_cnt == 9) ? 0 : tick_cnt + 1;
      iTick_1ms = (tick_cnt == 0);
      for (int i = 0; i < 4; i++) begin
        if (!oRail_EN[i] || stuck[i] || drop[i]) begin
          lat[i]      = 0;
          iRail_PG[i] = 1'b0;
        end else if (lat[i] < 4) begin
          lat[i] = lat[i] + 1;
        end else begin
          iRail_PG[i] = 1'b1;
        end
      end
    end
  end

  function automatic snap_t cur_snap();
    return {oState, oRail_EN, oSeq_Flt, oRun_Flt, oLeak, oAll_Good, oRail_Idx};
  endfunction

  function automatic snap_t mk(input logic [3:0] st, input logic [3:0] en, input logic [3:0] sq,
                               input logic [3:0] rn, input logic lk, input logic ag,
                               input logic [3:0] ix);
    return {st, en, sq, rn, lk, ag, ix};
  endfunction

  task automatic push(input logic [3:0] st, input logic [3:0] en, input logic [3:0] sq,
                      input logic [3:0] rn, input logic lk, input logic ag, input logic [3:0] ix);
    exp_q.push_back(mk(st, en, sq, rn, lk, ag, ix));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every change of the observable output vector consumes one expectation.
  initial begin
    last = '0;
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        last = cur_snap();
      end else if (cur_snap() !== last) begin
        last = cur_snap();
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got %h expected none", last);
        end else begin
          snap_t e;
          e = exp_q.pop_front();
          if (last !== e) begin
            n_fail++;
            $display("FAIL scoreboard: got %h expected %h", last, e);
          end
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge iClk);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_en(input logic [3:0] v, input int budget);
    int k;
    k = 0;
    while (oRail_EN !== v && k < budget) begin
      @(negedge iClk);
      k++;
    end
    if (oRail_EN !== v) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_en: got %h expected %h", oRail_EN, v);
    end
  endtask

  task automatic up_chain();
    push(4'h3, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h3, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    push(4'h3, 4'b0111, 4'h0, 4'h0, 1'b0, 1'b0, 4'd2);
    push(4'h3, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0, 4'd3);
    push(4'h0, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b1, 4'd3);
  endtask

  task automatic pulse_clr();
    @(negedge iClk);
    iFault_Clr = 1'b1;
    @(negedge iClk);
    iFault_Clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    iRst_n = 1'b0; iAux_Good = 1'b0; iPwr_Req = 1'b0; iLeak_N = 1'b1; iFault_Clr = 1'b0;
    iRail_Dly = {4{16'd2}}; iPG_Timeout = 16'd20; stuck = '0; drop = '0;
    repeat (3) @(negedge iClk);
    check("reset_state", cur_snap(), mk(4'h9, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0));
    iRst_n = 1'b1;

    // Nominal bring-up
    push(4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    iAux_Good = 1'b1;
    drain("standby", 50);
    up_chain();
    iPwr_Req = 1'b1;
    drain("nominal_up", 2000);

    // Runtime fault on rail 1
    push(4'h2, 4'b0111, 4'h0, 4'b0010, 1'b0, 1'b0, 4'd3);
    push(4'h2, 4'b0011, 4'h0, 4'b0010, 1'b0, 1'b0, 4'd2);
    push(4'h2, 4'b0001, 4'h0, 4'b0010, 1'b0, 1'b0, 4'd1);
    push(4'h2, 4'b0000, 4'h0, 4'b0010, 1'b0, 1'b0, 4'd0);
    push(4'hF, 4'b0000, 4'h0, 4'b0010, 1'b0, 1'b0, 4'd0);
    drop = 4'b0010;
    drain("run_fault", 2000);
    iPwr_Req = 1'b0;
    repeat (10) @(negedge iClk);
    drop = '0;
    push(4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    pulse_clr();
    drain("run_clr", 50);

    // Sequencing timeout on rail 2
    stuck = 4'b0100;
    push(4'h3, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h3, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    push(4'h3, 4'b0111, 4'h0, 4'h0, 1'b0, 1'b0, 4'd2);
    push(4'h2, 4'b0011, 4'b0100, 4'h0, 1'b0, 1'b0, 4'd2);
    push(4'h2, 4'b0001, 4'b0100, 4'h0, 1'b0, 1'b0, 4'd1);
    push(4'h2, 4'b0000, 4'b0100, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'hF, 4'b0000, 4'b0100, 4'h0, 1'b0, 1'b0, 4'd0);
    iPwr_Req = 1'b1;
    drain("seq_timeout", 3000);
    iPwr_Req = 1'b0;
    stuck = '0;
    push(4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    pulse_clr();
    drain("seq_clr", 50);

    // Zero delay: next enable exactly 3 cycles after raw PG rise
    iRail_Dly = '0;
    up_chain();
    iPwr_Req = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge iClk);
      #1;
      if (iRail_PG[0]) break;
    end
    repeat (2) @(posedge iClk);
    #1 check("dly0_en1_early", {31'd0, oRail_EN[1]}, 0);
    @(posedge iClk);
    #1 check("dly0_en1_3cyc", {31'd0, oRail_EN[1]}, 1);
    drain("dly0_up", 2000);
    push(4'h2, 4'b0111, 4'h0, 4'h0, 1'b0, 1'b0, 4'd3);
    push(4'h2, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, 4'd2);
    push(4'h2, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    push(4'h2, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h7, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    @(negedge iClk);
    iPwr_Req = 1'b0;
    drain("req_drop_on", 2000);

    // Request dropped mid-UP
    stuck = 4'b0010;
    push(4'h3, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h3, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    iPwr_Req = 1'b1;
    wait_en(4'b0011, 500);
    push(4'h2, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    push(4'h2, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h7, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    @(negedge iClk);
    iPwr_Req = 1'b0;
    drain("req_drop_up", 2000);
    stuck = '0;

    // Leak during UP at idx 2
    stuck = 4'b0100;
    push(4'h3, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h3, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    push(4'h3, 4'b0111, 4'h0, 4'h0, 1'b0, 1'b0, 4'd2);
    iPwr_Req = 1'b1;
    wait_en(4'b0111, 500);
    push(4'hE, 4'b0000, 4'h0, 4'h0, 1'b1, 1'b0, 4'd2);
    @(negedge iClk);
    iLeak_N = 1'b0;
    repeat (2) @(posedge iClk);
    #1 check("leak_en_2cyc", {28'd0, oRail_EN}, 32'h7);
    @(posedge iClk);
    #1 check("leak_en_3cyc", {28'd0, oRail_EN}, 32'h0);
    pulse_clr();
    iPwr_Req = 1'b0;
    repeat (20) @(negedge iClk);
    iPwr_Req = 1'b1;
    repeat (20) @(negedge iClk);
    iPwr_Req = 1'b0;
    repeat (20) @(negedge iClk);
    check("leak_sticky_state", {28'd0, oState}, 32'hE);
    check("leak_sticky_flag", {31'd0, oLeak}, 1);
    drain("leak", 50);

    // Reset clears LEAK; then an asynchronous reset mid-UP
    iRst_n = 1'b0;
    iLeak_N = 1'b1;
    stuck = '0;
    repeat (3) @(negedge iClk);
    push(4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    iRst_n = 1'b1;
    drain("post_reset", 50);
    stuck = 4'b0010;
    push(4'h3, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    push(4'h3, 4'b0011, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1);
    iPwr_Req = 1'b1;
    wait_en(4'b0011, 500);
    @(negedge iClk);
    #2 iRst_n = 1'b0;
    #1 check("async_reset", cur_snap(), mk(4'h9, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0));
    iPwr_Req = 1'b0;
    stuck = '0;
    repeat (3) @(negedge iClk);
    push(4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    iRst_n = 1'b1;
    drain("reset_recover", 50);

    // Aux loss and leak coincide in ON: aux loss wins
    up_chain();
    iPwr_Req = 1'b1;
    drain("sim_up", 2000);
    push(4'h9, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0);
    @(negedge iClk);
    iAux_Good = 1'b0;
    iLeak_N = 1'b0;
    drain("aux_over_leak", 50);
    repeat (30) @(negedge iClk);
    check("aux_leak_flag", {31'd0, oLeak}, 0);
    check("aux_idle_state", {28'd0, oState}, 32'h9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
